spike_classifier: RTL and testbench

Output-side stage directly downstream of the `network` output port. It consumes the byte-serialised output-layer spike stream (`OUT_VALID`/`OUT_SPIKE`) and reassembles each beat pair into a 16-channel spike vector. It accumulates per-channel spike counts over the T timesteps of one image, then runs a sequential argmax to report the winning class per image. It has no backpressure, because the network cannot be stalled.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/spike_accum.sv | 65 ++++++
 rtl/spike_classifier.sv | 113 +++++++++++
 tb/tb_spike_classifier.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants, FSM state type and counter helper for the spike output stage.
package snn_pkg;

  localparam int IO_WIDTH  = 8;
  localparam int CK        = 16;
  localparam int T_WIDTH   = 5;
  localparam int CNT_WIDTH = 8;

  localparam int NBEATS    = CK / IO_WIDTH;
  localparam int B_WIDTH   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IDX_WIDTH = $clog2(CK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Increment by one unless the counter already sits at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

endpackage

// File: rtl/spike_accum.sv
// Per-channel saturating spike accumulators with beat/timestep tracking.
// sum_next is the accumulator value including the current beat, so the
// parent can snapshot a complete image on the img_end cycle.
module spike_accum
  import snn_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [T_WIDTH-1:0]      T_M1,
  input  logic                    IN_VALID,
  input  logic [IO_WIDTH-1:0]     IN_SPIKE,
  output logic                    img_end,
  output logic [CK*CNT_WIDTH-1:0] sum_next
);

  logic [B_WIDTH-1:0]   b;
  logic [T_WIDTH-1:0]   t;
  logic [T_WIDTH-1:0]   t_m1_q;
  logic [T_WIDTH-1:0]   tm1_eff;
  logic [CNT_WIDTH-1:0] acc [CK];
  logic [CK-1:0]        hit;
  logic                 first_beat;
  logic                 last_beat;

  // Image boundary decode; the live T_M1 only matters on the latching beat.
  always_comb begin
    first_beat = (b == '0) && (t == '0);
    last_beat  = (b == B_WIDTH'(NBEATS - 1));
    tm1_eff    = first_beat ? T_M1 : t_m1_q;
    img_end    = IN_VALID && last_beat && (t == tm1_eff);
  end

  // Map the current beat onto its channel slice and form incremented counts.
  always_comb begin
    hit      = '0;
    sum_next = '0;
    for (int c = 0; c < CK; c++) begin
      hit[c] = IN_VALID && (b == B_WIDTH'(c / IO_WIDTH)) && IN_SPIKE[c % IO_WIDTH];
      sum_next[c*CNT_WIDTH +: CNT_WIDTH] = sat_inc(acc[c], hit[c]);
    end
  end

  // Beat/timestep counters, T_M1 latch and accumulators (cleared at image end).
  always_ff @(posedge CLK) begin
    if (RST) begin
      b      <= '0;
      t      <= '0;
      t_m1_q <= '0;
      for (int c = 0; c < CK; c++) acc[c] <= '0;
    end else begin
      if (IN_VALID) begin
        if (first_beat) t_m1_q <= T_M1;
        if (last_beat) begin
          b <= '0;
          t <= (t == tm1_eff) ? '0 : t + T_WIDTH'(1);
        end else begin
          b <= b + B_WIDTH'(1);
        end
      end
      for (int c = 0; c < CK; c++)
        acc[c] <= img_end ? '0 : sum_next[c*CNT_WIDTH +: CNT_WIDTH];
    end
  end

endmodule

// File: rtl/spike_classifier.sv
// Reassembles output-layer spikes into per-class counts and reports the
// argmax class once per image. No backpressure: an image that ends while a
// scan is still running is dropped and flagged through OVERRUN.
// Handshake: OUT_VALID is a one-cycle pulse with no ready; OUT_CLASS,
// OUT_COUNT and OUT_ZERO are valid while it is high and hold afterwards.
module spike_classifier
  import snn_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [T_WIDTH-1:0]   T_M1,
  input  logic                 IN_VALID,
  input  logic [IO_WIDTH-1:0]  IN_SPIKE,
  output logic                 OUT_VALID,
  output logic [IDX_WIDTH-1:0] OUT_CLASS,
  output logic [CNT_WIDTH-1:0] OUT_COUNT,
  output logic                 OUT_ZERO,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output state_t               DBG_STATE
);

  state_t               state, state_nxt;
  logic                 img_end;
  logic [CK*CNT_WIDTH-1:0] sum_next;
  logic [CNT_WIDTH-1:0] snap [CK];
  logic [IDX_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] best;
  logic [IDX_WIDTH-1:0] best_idx;
  logic [CNT_WIDTH-1:0] fin_count;
  logic [IDX_WIDTH-1:0] fin_idx;
  logic                 take;
  logic                 last_idx;

  spike_accum u_accum (
    .CLK      (CLK),
    .RST      (RST),
    .T_M1     (T_M1),
    .IN_VALID (IN_VALID),
    .IN_SPIKE (IN_SPIKE),
    .img_end  (img_end),
    .sum_next (sum_next)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: start on an image end, one channel per SCAN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (img_end)  state_nxt = SCAN;
      SCAN:    if (last_idx) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    BUSY      = (state == SCAN);
    OUT_VALID = (state == DONE);
    DBG_STATE = state;
  end

  // Compare step: strictly greater replaces, so ties keep the lower index.
  always_comb begin
    last_idx  = (idx == IDX_WIDTH'(CK - 1));
    take      = (snap[idx] > best);
    fin_count = take ? snap[idx] : best;
    fin_idx   = take ? idx : best_idx;
  end

  // Snapshot buffer, scan datapath, result registers and overrun flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CK; c++) snap[c] <= '0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      OUT_CLASS <= '0;
      OUT_COUNT <= '0;
      OUT_ZERO  <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (img_end) begin
        if (state == IDLE) begin
          for (int c = 0; c < CK; c++) snap[c] <= sum_next[c*CNT_WIDTH +: CNT_WIDTH];
        end else begin
          OVERRUN <= 1'b1;
        end
      end
      if (state == SCAN) begin
        idx      <= idx + IDX_WIDTH'(1);
        best     <= fin_count;
        best_idx <= fin_idx;
        if (last_idx) begin
          OUT_CLASS <= fin_idx;
          OUT_COUNT <= fin_count;
          OUT_ZERO  <= (fin_count == '0);
        end
      end else begin
        idx      <= '0;
        best     <= '0;
        best_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spike_classifier.sv
// Directed bench for spike_classifier: latency, argmax/tie/zero cases,
// overrun behaviour, mid-image reset and IN_VALID gaps with a T_M1 change.
module tb_spike_classifier;
  import snn_pkg::*;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [T_WIDTH-1:0]   T_M1 = '0;
  logic                 IN_VALID = 1'b0;
  logic [IO_WIDTH-1:0]  IN_SPIKE = '0;
  logic                 OUT_VALID;
  logic [IDX_WIDTH-1:0] OUT_CLASS;
  logic [CNT_WIDTH-1:0] OUT_COUNT;
  logic                 OUT_ZERO;
  logic                 BUSY;
  logic                 OVERRUN;
  state_t               DBG_STATE;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  logic [11:0] got_q[$];

  spike_classifier dut (
    .CLK       (CLK),
    .RST       (RST),
    .T_M1      (T_M1),
    .IN_VALID  (IN_VALID),
    .IN_SPIKE  (IN_SPIKE),
    .OUT_VALID (OUT_VALID),
    .OUT_CLASS (OUT_CLASS),
    .OUT_COUNT (OUT_COUNT),
    .OUT_ZERO  (OUT_ZERO),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .DBG_STATE (DBG_STATE)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // Result monitor: records every OUT_VALID pulse as {class, count}.
  always @(negedge CLK) begin
    if (OUT_VALID) begin
      valid_cnt++;
      got_q.push_back({OUT_CLASS, OUT_COUNT});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One beat, optionally preceded by idle cycles; IN_VALID stays continuous
  // when consecutive beats have no gap.
  task automatic beat(input logic [IO_WIDTH-1:0] d, input int gap);
    repeat (gap) begin
      IN_VALID = 1'b0;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b1;
    IN_SPIKE = d;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_SPIKE = '0;
  endtask

  // Eight-timestep image. kind: 0 = ch5 x8 + ch9 x3, 1 = tie ch3/ch12 x4,
  // 2 = all zero, 3 = ch15 x8. gapmax > 0 inserts random idle cycles;
  // chg_tm1 rewrites T_M1 after the first beat.
  task automatic send_img(input int kind, input int gapmax, input bit chg_tm1);
    logic [7:0] lo, hi;
    for (int s = 0; s < 8; s++) begin
      lo = 8'h00; hi = 8'h00;
      case (kind)
        0: begin lo = 8'h20; hi = (s < 3) ? 8'h02 : 8'h00; end
        1: begin lo = (s < 4) ? 8'h08 : 8'h00; hi = (s >= 4) ? 8'h10 : 8'h00; end
        3: hi = 8'h80;
        default: ;
      endcase
      beat(lo, (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
      if (chg_tm1 && s == 0) T_M1 = 5'd3;
      beat(hi, (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
    end
  endtask

  // Waits for the result after the final beat; expects it CK+1 edges later.
  task automatic wait_result(input string tag, input int cls, input int cnt, input int zero);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (i == 1) check({tag, "_busy_start"}, BUSY, 1);
      if (i == CK) check({tag, "_busy_end"}, BUSY, 1);
      if (OUT_VALID) begin
        k = i;
        break;
      end
    end
    check({tag, "_latency"}, k, CK + 1);
    check({tag, "_class"}, OUT_CLASS, cls);
    check({tag, "_count"}, OUT_COUNT, cnt);
    check({tag, "_zero"}, OUT_ZERO, zero);
    check({tag, "_busy_done"}, BUSY, 0);
    @(negedge CLK);
    check({tag, "_pulse_one_cycle"}, OUT_VALID, 0);
    check({tag, "_class_hold"}, OUT_CLASS, cls);
  endtask

  initial begin
    int vc0;
    logic [11:0] r;

    // Reset.
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_valid", OUT_VALID, 0);
    check("rst_class", OUT_CLASS, 0);
    check("rst_count", OUT_COUNT, 0);
    check("rst_zero", OUT_ZERO, 0);
    check("rst_busy", BUSY, 0);
    check("rst_overrun", OVERRUN, 0);

    // Basic argmax.
    @(posedge CLK); #1;
    T_M1 = 5'd7;
    send_img(0, 0, 1'b0);
    wait_result("basic", 5, 8, 0);

    // Tie goes to the lowest index.
    send_img(1, 0, 1'b0);
    wait_result("tie", 3, 4, 0);

    // All-zero image.
    send_img(2, 0, 1'b0);
    wait_result("zero", 0, 0, 1);
    check("no_overrun_yet", OVERRUN, 0);

    // T_M1=0, continuous beats: images 0 and 9 land in IDLE, the rest overrun.
    got_q.delete();
    vc0 = valid_cnt;
    T_M1 = 5'd0;
    for (int img = 0; img < 10; img++) begin
      if (img == 0)      begin beat(8'h01, 0); beat(8'h00, 0); end
      else if (img == 9) begin beat(8'h00, 0); beat(8'h40, 0); end
      else               begin beat(8'hFF, 0); beat(8'hFF, 0); end
      if (img == 0) check("overrun_after_img0", OVERRUN, 0);
      if (img == 1) check("overrun_after_img1", OVERRUN, 1);
    end
    repeat (30) @(negedge CLK);
    check("overrun_results", valid_cnt - vc0, 2);
    check("overrun_sticky", OVERRUN, 1);
    r = (got_q.size() > 0) ? got_q.pop_front() : 12'hFFF;
    check("overrun_img0_class", r[11:8], 0);
    check("overrun_img0_count", r[7:0], 1);
    r = (got_q.size() > 0) ? got_q.pop_front() : 12'hFFF;
    check("overrun_img9_class", r[11:8], 14);
    check("overrun_img9_count", r[7:0], 1);

    // Reset on beat 9 of a busy image, then a clean image.
    @(posedge CLK); #1;
    T_M1 = 5'd7;
    for (int i = 0; i < 9; i++) beat(8'hFF, 0);
    IN_VALID = 1'b1;
    IN_SPIKE = 8'hFF;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    IN_VALID = 1'b0;
    IN_SPIKE = '0;
    @(negedge CLK);
    check("midrst_overrun", OVERRUN, 0);
    check("midrst_class", OUT_CLASS, 0);
    check("midrst_count", OUT_COUNT, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_valid", OUT_VALID, 0);
    @(posedge CLK); #1;
    vc0 = valid_cnt;
    send_img(3, 0, 1'b0);
    wait_result("after_rst", 15, 8, 0);
    repeat (5) @(negedge CLK);
    check("after_rst_one_valid", valid_cnt - vc0, 1);

    // Random gaps and a mid-image T_M1 change; latched value must win.
    T_M1 = 5'd7;
    send_img(0, 3, 1'b1);
    wait_result("gaps", 5, 8, 0);
    check("gaps_overrun", OVERRUN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
